// File: rtl/poly1305_block_serial_pkg.sv
// Shared constants, state encoding and the 2^130 == 5 (mod P) fold for the serial Poly1305 block step.
package poly1305_pkg;

    localparam logic [129:0] P_CONST    = {130{1'b1}} - 130'd4;
    localparam logic [127:0] CLAMP_MASK = 128'h0ffffffc0ffffffc0ffffffc0fffffff;
    // Widest fold input: 132 + largest digit width (64).
    localparam int           FOLD_W     = 196;

    typedef enum logic [2:0] {
        IDLE,
        SUM,
        MUL,
        RED,
        CAN
    } state_e;

    function automatic logic [130:0] fold130(input logic [FOLD_W-1:0] x);
        logic [FOLD_W-131:0] hi;
        logic [FOLD_W-128:0] hi5;
        hi  = x[FOLD_W-1:130];
        hi5 = {1'b0, hi, 2'b00} + {3'b000, hi};
        return {1'b0, x[129:0]} + 131'(hi5);
    endfunction

endpackage

// File: rtl/poly1305_block_serial_if.sv
// Request/response bundle between the block buffer, the serial block step and the tag finaliser.
interface poly1305_block_serial_if;

    logic [127:0] r;
    logic [128:0] m;
    logic [129:0] a_in;
    logic         start;
    logic         busy;
    logic         done;
    logic [129:0] a_out;

    modport master (output r, m, a_in, start, input busy, done, a_out);
    modport slave  (input r, m, a_in, start, output busy, done, a_out);

endinterface

// File: rtl/poly1305_block_serial_fold.sv
// Folds bits >= 130 back in with weight 5; purely combinational.
// Latency: 0 cycles. Backpressure: none.
module poly1305_fold
    import poly1305_pkg::*;
#(
    parameter int IN_W = 131
) (
    input  logic [IN_W-1:0] x_i,
    output logic [130:0]    y_o
);

    logic [FOLD_W-1:0] x_ext;

    always_comb begin
        x_ext            = '0;
        x_ext[IN_W-1:0]  = x_i;
    end

    assign y_o = fold130(x_ext);

endmodule

// File: rtl/poly1305_block_serial.sv
// Serial Poly1305 block step: a_out = ((a_in + m) * r) mod (2^130-5), one r digit per cycle, MSB first.
// Latency: NDIG+3 cycles from accept edge to done pulse; one request in flight.
// Backpressure: start is only taken while idle; requests raised while busy are dropped, not queued.
module poly1305_block_serial
    import poly1305_pkg::*;
#(
    parameter int DIGIT_W = 16,
    parameter bit CLAMP   = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    poly1305_block_serial_if.slave blk
);

    localparam int NDIG  = 128 / DIGIT_W;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int T_W   = 132 + DIGIT_W;

    state_e             state_q, state_d;
    logic [127:0]       r_q, r_d;
    logic [128:0]       m_q, m_d;
    logic [129:0]       a_q, a_d;
    logic [130:0]       h_q, h_d;
    logic [130:0]       p_q, p_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [129:0]       a_out_q, a_out_d;
    logic               done_q, done_d;

    logic [DIGIT_W-1:0] digit;
    logic [T_W-1:0]     t;
    logic [130:0]       p_mul;
    logic [130:0]       p_red;
    logic [129:0]       p_sub;

    assign digit = r_q[int'(cnt_q)*DIGIT_W +: DIGIT_W];
    assign t     = {1'b0, p_q, {DIGIT_W{1'b0}}} + (T_W'(h_q) * T_W'(digit));
    // p < 2^130+5 in CAN, so the 130-bit wrap of p-P is exact whenever p >= P.
    assign p_sub = p_q[129:0] - P_CONST;

    poly1305_fold #(.IN_W(T_W)) u_fold_mul (.x_i(t),   .y_o(p_mul));
    poly1305_fold #(.IN_W(131)) u_fold_red (.x_i(p_q), .y_o(p_red));

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        m_d     = m_q;
        a_d     = a_q;
        h_d     = h_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        a_out_d = a_out_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (blk.start) begin
                    r_d     = CLAMP ? (blk.r & CLAMP_MASK) : blk.r;
                    m_d     = blk.m;
                    a_d     = blk.a_in;
                    state_d = SUM;
                end
            end
            SUM: begin
                h_d     = {1'b0, a_q} + {2'b00, m_q};
                p_d     = '0;
                cnt_d   = CNT_W'(NDIG - 1);
                state_d = MUL;
            end
            MUL: begin
                p_d   = p_mul;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = RED;
                end
            end
            RED: begin
                p_d     = p_red;
                state_d = CAN;
            end
            CAN: begin
                a_out_d = (p_q >= {1'b0, P_CONST}) ? p_sub : p_q[129:0];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            r_q     <= '0;
            m_q     <= '0;
            a_q     <= '0;
            h_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            a_out_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            m_q     <= m_d;
            a_q     <= a_d;
            h_q     <= h_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            a_out_q <= a_out_d;
            done_q  <= done_d;
        end
    end

    assign blk.busy  = (state_q != IDLE);
    assign blk.done  = done_q;
    assign blk.a_out = a_out_q;

endmodule

// File: tb/tb_poly1305_block_serial.sv
// Drives a 16-bit-digit unclamped and a 64-bit-digit clamped instance side by side against a bignum model.
module tb_poly1305_block_serial;

    localparam int DW0  = 16;
    localparam int DW1  = 64;
    localparam int LAT0 = 128 / DW0 + 3;
    localparam int LAT1 = 128 / DW1 + 3;
    localparam int HOLD = 25;
    localparam logic [129:0] PRIME = {130{1'b1}} - 130'd4;
    localparam logic [127:0] RMASK = 128'h0ffffffc0ffffffc0ffffffc0fffffff;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    poly1305_block_serial_if bus0 ();
    poly1305_block_serial_if bus1 ();

    poly1305_block_serial #(.DIGIT_W(DW0), .CLAMP(1'b0)) dut0 (.clk(clk), .reset(reset), .blk(bus0.slave));
    poly1305_block_serial #(.DIGIT_W(DW1), .CLAMP(1'b1)) dut1 (.clk(clk), .reset(reset), .blk(bus1.slave));

    task automatic check_eq(input string tag, input logic [259:0] got, input logic [259:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [129:0] ref_block(input logic [129:0] a, input logic [128:0] m,
                                               input logic [127:0] r, input bit clamp);
        logic [263:0] x;
        logic [263:0] rr;
        rr = clamp ? {136'd0, r & RMASK} : {136'd0, r};
        x  = ({134'd0, a} + {135'd0, m}) * rr;
        x  = x % {134'd0, PRIME};
        return x[129:0];
    endfunction

    function automatic logic [129:0] rnd130();
        logic [159:0] w;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return w[129:0];
    endfunction

    task automatic scramble();
        logic [129:0] w;
        w = rnd130(); bus0.r = w[127:0]; bus0.m = w[128:0]; bus0.a_in = rnd130();
        w = rnd130(); bus1.r = w[127:0]; bus1.m = w[128:0]; bus1.a_in = rnd130();
    endtask

    // Called on a falling edge with both instances idle; returns on a falling edge with both idle again.
    task automatic run_op(input logic [127:0] r, input logic [128:0] m,
                          input logic [129:0] a0, input logic [129:0] a1,
                          output logic [129:0] q0, output logic [129:0] q1);
        int cyc;
        bit seen0;
        bit seen1;
        bus0.r = r; bus0.m = m; bus0.a_in = a0; bus0.start = 1'b1;
        bus1.r = r; bus1.m = m; bus1.a_in = a1; bus1.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        check_eq("busy0_after_accept", bus0.busy, 1'b1);
        check_eq("busy1_after_accept", bus1.busy, 1'b1);
        cyc = 1; seen0 = 1'b0; seen1 = 1'b0; q0 = '0; q1 = '0;
        while (!(seen0 && seen1) && cyc < 64) begin
            scramble();
            @(negedge clk);
            cyc++;
            if (!seen0 && bus0.done) begin
                seen0 = 1'b1;
                q0 = bus0.a_out;
                check_eq("latency0", cyc - 1, LAT0);
                check_eq("busy0_in_done", bus0.busy, 1'b0);
            end
            if (!seen1 && bus1.done) begin
                seen1 = 1'b1;
                q1 = bus1.a_out;
                check_eq("latency1", cyc - 1, LAT1);
                check_eq("busy1_in_done", bus1.busy, 1'b0);
            end
        end
        if (!seen0) check_eq("timeout0", 1'b0, 1'b1);
        if (!seen1) check_eq("timeout1", 1'b0, 1'b1);
    endtask

    initial begin
        logic [129:0] q0, q1, e0, e1, a0, a1;
        logic [128:0] m;
        logic [127:0] r;
        logic [127:0] s_key;
        logic [127:0] tag;
        string        msg;
        int           n0, n1, len;

        bus0.r = '0; bus0.m = '0; bus0.a_in = '0; bus0.start = 1'b0;
        bus1.r = '0; bus1.m = '0; bus1.a_in = '0; bus1.start = 1'b0;
        #2;
        check_eq("rst_busy0", bus0.busy, 1'b0);
        check_eq("rst_done0", bus0.done, 1'b0);
        check_eq("rst_aout0", bus0.a_out, 130'd0);
        check_eq("rst_aout1", bus1.a_out, 130'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // T1: identity multiplier, plus single-cycle done pulse
        m = (129'd1 << 128) + 129'd1;
        run_op(128'd1, m, 130'd0, 130'd0, q0, q1);
        e0 = (130'd1 << 128) + 130'd1;
        check_eq("t1_res0", q0, e0);
        check_eq("t1_res1", q1, e0);
        @(negedge clk);
        check_eq("t1_done0_pulse", bus0.done, 1'b0);
        check_eq("t1_hold0", bus0.a_out, e0);

        // T2: wrap through P
        a0 = PRIME - 130'd1;
        run_op(128'd2, 129'd1 << 128, a0, a0, q0, q1);
        e0 = (130'd1 << 129) - 130'd2;
        check_eq("t2_res0", q0, e0);
        check_eq("t2_res1", q1, e0);

        // T3: unreduced accumulator needs the final subtract
        a0 = {130{1'b1}};
        run_op(128'd1, 129'd1 << 128, a0, a0, q0, q1);
        e0 = (130'd1 << 128) + 130'd4;
        check_eq("t3_res0", q0, e0);
        check_eq("t3_res1", q1, e0);

        // T4: all-ones r, clamped vs unclamped
        r = {128{1'b1}};
        run_op(r, 129'd1 << 128, 130'd0, 130'd0, q0, q1);
        check_eq("t4_unclamped", q0, ref_block(130'd0, 129'd1 << 128, r, 1'b0));
        check_eq("t4_clamped", q1, ref_block(130'd0, 129'd1 << 128, r, 1'b1));

        // T5: start held high; only requests seen while idle are taken
        a0 = rnd130(); r = rnd130(); m = rnd130();
        bus0.r = r; bus0.m = m; bus0.a_in = a0; bus0.start = 1'b1;
        bus1.r = r; bus1.m = m; bus1.a_in = a0; bus1.start = 1'b1;
        e0 = ref_block(a0, m, r, 1'b0);
        e1 = ref_block(a0, m, r, 1'b1);
        n0 = 0; n1 = 0;
        for (int k = 1; k <= HOLD + LAT0 + 4; k++) begin
            @(negedge clk);
            if (k == HOLD) begin
                bus0.start = 1'b0;
                bus1.start = 1'b0;
            end
            if (bus0.done) begin n0++; check_eq("t5_res0", bus0.a_out, e0); end
            if (bus1.done) begin n1++; check_eq("t5_res1", bus1.a_out, e1); end
        end
        check_eq("t5_pulses0", n0, (HOLD - 1) / (LAT0 + 1) + 1);
        check_eq("t5_pulses1", n1, (HOLD - 1) / (LAT1 + 1) + 1);

        // T6: reset during the multiply phase
        bus0.start = 1'b1; bus1.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0; bus1.start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("t6_busy0", bus0.busy, 1'b0);
        check_eq("t6_busy1", bus1.busy, 1'b0);
        check_eq("t6_aout0", bus0.a_out, 130'd0);
        check_eq("t6_aout1", bus1.a_out, 130'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        n0 = 0;
        for (int k = 0; k < LAT0 + 4; k++) begin
            @(negedge clk);
            if (bus0.done || bus1.done) n0++;
        end
        check_eq("t6_no_done", n0, 0);
        a0 = rnd130(); a1 = rnd130(); r = rnd130(); m = rnd130();
        run_op(r, m, a0, a1, q0, q1);
        check_eq("t6_after0", q0, ref_block(a0, m, r, 1'b0));
        check_eq("t6_after1", q1, ref_block(a1, m, r, 1'b1));

        // RFC 8439 2.5.2 message chained through both instances
        msg   = "Cryptographic Forum Research Group";
        r     = 128'ha806d542fe52447f336d555778bed685;
        s_key = 128'h1bf54941aff6bf4afdb20dfb8a800301;
        a0 = '0; a1 = '0; e0 = '0; e1 = '0;
        for (int b = 0; b < 3; b++) begin
            len = (msg.len() - 16 * b > 16) ? 16 : msg.len() - 16 * b;
            m = '0;
            for (int i = 0; i < len; i++) m = m | (129'(msg[16 * b + i]) << (8 * i));
            m = m | (129'd1 << (8 * len));
            e0 = ref_block(e0, m, r, 1'b0);
            e1 = ref_block(e1, m, r, 1'b1);
            run_op(r, m, a0, a1, q0, q1);
            check_eq("rfc_chain0", q0, e0);
            check_eq("rfc_chain1", q1, e1);
            a0 = q0; a1 = q1;
        end
        tag = a1[127:0] + s_key;
        check_eq("rfc_tag", tag, 128'ha927010caf8b2bc2c6365130c11d06a8);

        // Random sweep with edge-biased accumulators
        for (int i = 0; i < 300; i++) begin
            r = rnd130(); m = rnd130();
            case ($urandom_range(0, 3))
                0:       a0 = {130{1'b1}} - 130'($urandom_range(0, 15));
                1:       a0 = PRIME - 130'($urandom_range(0, 15));
                default: a0 = rnd130();
            endcase
            a1 = rnd130();
            run_op(r, m, a0, a1, q0, q1);
            check_eq("rand0", q0, ref_block(a0, m, r, 1'b0));
            check_eq("rand1", q1, ref_block(a1, m, r, 1'b1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
